// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage access states, alignment mask and timing defaults.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mau_state_e;

    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;
    localparam int unsigned TIMEOUT_CTR_W   = 8;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts REQ cycles without an ack; tc_c fires in the cycle the count sits at TIMEOUT_CYC-1.
module mem_timeout_ctr
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam logic [TIMEOUT_CTR_W-1:0] TC_VAL = TIMEOUT_CTR_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_CTR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TIMEOUT_CTR_W'(1);
        end
    end

    assign tc_c = enable && (count == TC_VAL);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues req/ack word accesses, stalls the pipeline while one is
// outstanding, returns load data and flags misaligned addresses and bus timeouts.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memwrite_m,
    input  logic              memtoreg_m,
    input  logic [DATA_W-1:0] alu_out_m,
    input  logic [DATA_W-1:0] wdata_m,
    output logic              stall_m,
    output logic [DATA_W-1:0] rdata_m,
    output logic              addr_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    mau_state_e state;

    logic access_c;
    logic aligned_c;
    logic ctr_en_c;
    logic ctr_clr_c;
    logic tc_c;

    assign access_c  = memwrite_m | memtoreg_m;
    assign aligned_c = is_word_aligned(alu_out_m[1:0]);
    assign ctr_en_c  = (state == REQ) && !mem_ack;
    assign ctr_clr_c = (state != REQ);

    // Hazard unit needs the stall in the same cycle the access is presented.
    always_comb begin
        stall_m = 1'b0;
        case (state)
            IDLE:    stall_m = access_c && aligned_c;
            REQ:     stall_m = 1'b1;
            default: stall_m = 1'b0;
        endcase
    end

    mem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .clear  (ctr_clr_c),
        .enable (ctr_en_c),
        .tc_c   (tc_c)
    );

    // Access sequencer; ack takes priority over a coincident timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_m   <= '0;
            addr_err  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (access_c) begin
                        if (aligned_c) begin
                            mem_req   <= 1'b1;
                            mem_we    <= memwrite_m;
                            mem_addr  <= alu_out_m;
                            mem_wdata <= wdata_m;
                            state     <= REQ;
                        end else begin
                            addr_err  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata_m <= mem_rdata;
                        end
                        state   <= DONE;
                    end else if (tc_c) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!mem_we) begin
                            rdata_m <= '0;
                        end
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver queues hand-computed results, monitor checks completions.
module tb_mem_access_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          memwrite_m;
    logic          memtoreg_m;
    logic [DW-1:0] alu_out_m;
    logic [DW-1:0] wdata_m;
    logic          stall_m;
    logic [DW-1:0] rdata_m;
    logic          addr_err;
    logic          bus_err;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    mem_access_unit #(
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memwrite_m (memwrite_m),
        .memtoreg_m (memtoreg_m),
        .alu_out_m  (alu_out_m),
        .wdata_m    (wdata_m),
        .stall_m    (stall_m),
        .rdata_m    (rdata_m),
        .addr_err   (addr_err),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        bit            we;
        logic [DW-1:0] rdata;
        bit            bus;
        int            stalls;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // Monitor: pops one expectation per addr_err pulse and per completed access (stall release).
    int stall_cnt  = 0;
    bit prev_stall = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            stall_cnt  = 0;
            prev_stall = 1'b0;
        end else begin
            if (stall_m) stall_cnt++;
            if (addr_err) begin
                if (q.size() == 0) begin
                    fail_now("addr_err_unexpected");
                end else begin
                    e = q.pop_front();
                    check("addr_err_kind", 32'(e.is_err), 32'(1));
                    check("addr_err_no_req", 32'(mem_req), 32'(0));
                end
            end
            if (prev_stall && !stall_m) begin
                if (q.size() == 0) begin
                    fail_now("completion_unexpected");
                end else begin
                    e = q.pop_front();
                    check("completion_kind", 32'(e.is_err), 32'(0));
                    check("rdata_m", rdata_m, e.rdata);
                    check("bus_err", 32'(bus_err), 32'(e.bus));
                    check("mem_we", 32'(mem_we), 32'(e.we));
                    check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                    check("mem_req_released", 32'(mem_req), 32'(0));
                end
                stall_cnt = 0;
            end
            prev_stall = stall_m;
        end
    end

    task automatic clear_inputs();
        memwrite_m = 1'b0;
        memtoreg_m = 1'b0;
        alu_out_m  = '0;
        wdata_m    = '0;
    endtask

    // ack_after: REQ cycle number carrying mem_ack (0 = never acked).
    task automatic do_access(input string tag, input logic w, input logic r,
                             input logic [DW-1:0] a, input logic [DW-1:0] d,
                             input int ack_after, input logic [DW-1:0] rd,
                             input logic [DW-1:0] exp_rdata, input bit exp_bus,
                             input int exp_stalls);
        exp_t e;
        bit   misaligned;
        bit   done;
        int   n;
        misaligned = (a[1:0] != 2'b00);
        e = '{is_err: misaligned, we: w, rdata: exp_rdata, bus: exp_bus, stalls: exp_stalls};
        q.push_back(e);
        memwrite_m = w;
        memtoreg_m = r;
        alu_out_m  = a;
        wdata_m    = d;
        #1;
        check({tag, "_stall_at_issue"}, 32'(stall_m), 32'(!misaligned));
        @(posedge clk); #1;
        if (misaligned) begin
            check({tag, "_no_req"}, 32'(mem_req), 32'(0));
            clear_inputs();
            @(posedge clk); #1;
            @(posedge clk); #1;
        end else begin
            done = 1'b0;
            n    = 1;
            while (!done && n <= 40) begin
                check({tag, "_req_held"}, 32'(mem_req), 32'(1));
                check({tag, "_addr_held"}, mem_addr, a);
                check({tag, "_wdata_held"}, mem_wdata, d);
                if (n == ack_after) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = '0;
                if (!stall_m) done = 1'b1;
                n++;
            end
            if (!done) fail_now({tag, "_no_completion"});
            clear_inputs();
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        clear_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_addr_err", 32'(addr_err), 32'(0));
        check("rst_bus_err", 32'(bus_err), 32'(0));
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rdata_m", rdata_m, 32'h0);
        check("rst_stall_m", 32'(stall_m), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        do_access("load_fast", 1'b0, 1'b1, 32'h0000_0010, 32'h0, 1, 32'hCAFE_F00D,
                  32'hCAFE_F00D, 1'b0, 2);
        do_access("store_slow", 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 5, 32'hFFFF_FFFF,
                  32'hCAFE_F00D, 1'b0, 6);
        do_access("load_misaligned", 1'b0, 1'b1, 32'h0000_0013, 32'h0, 1, 32'h0,
                  32'hCAFE_F00D, 1'b0, 0);
        do_access("store_misaligned", 1'b1, 1'b0, 32'h0000_0042, 32'hAAAA_0000, 1, 32'h0,
                  32'hCAFE_F00D, 1'b0, 0);
        do_access("load_ack_at_timeout", 1'b0, 1'b1, 32'h0000_0030, 32'h0, TO, 32'h0BAD_BEEF,
                  32'h0BAD_BEEF, 1'b0, TO + 1);
        do_access("both_is_store", 1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 2, 32'h5555_5555,
                  32'h0BAD_BEEF, 1'b0, 3);
        check("both_is_store_addr", mem_addr, 32'h0000_0040);

        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_DEAD;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("idle_ack_rdata", rdata_m, 32'h0BAD_BEEF);
        check("idle_ack_req", 32'(mem_req), 32'(0));
        check("idle_ack_stall", 32'(stall_m), 32'(0));
        @(posedge clk); #1;

        do_access("load_timeout", 1'b0, 1'b1, 32'h0000_0050, 32'h0, 0, 32'h0,
                  32'h0, 1'b1, TO + 1);
        repeat (3) @(posedge clk);
        #1;
        check("bus_err_sticky", 32'(bus_err), 32'(1));
        do_access("load_after_timeout", 1'b0, 1'b1, 32'h0000_0054, 32'h0, 1, 32'h1111_2222,
                  32'h1111_2222, 1'b1, 2);

        memtoreg_m = 1'b1;
        alu_out_m  = 32'h0000_0060;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_req_before_rst", 32'(mem_req), 32'(1));
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_mem_req", 32'(mem_req), 32'(0));
        check("abort_stall_m", 32'(stall_m), 32'(0));
        check("abort_bus_err", 32'(bus_err), 32'(0));
        @(posedge clk); #1;

        do_access("load_after_abort", 1'b0, 1'b1, 32'h0000_0070, 32'h0, 1, 32'h7777_0000,
                  32'h7777_0000, 1'b0, 2);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
